isqrt_iter: RTL

ISQRT_ITER -- requirements
Module: isqrt_iter

---
 rtl/isqrt_pkg.sv | 19 +
 rtl/isqrt_step.sv | 30 +++
 rtl/isqrt_iter.sv | 94 +++++++++
 3 files changed

// File: rtl/isqrt_pkg.sv
// Shared widths, FSM state encoding and latency helper for the iterative
// integer square root.
package isqrt_pkg;

    localparam int ISQRT_X_W = 32;  // radicand width
    localparam int ISQRT_Y_W = 16;  // root width
    localparam int ISQRT_R_W = 18;  // partial remainder width

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Cycles from acceptance to result for a given number of digit steps per clock.
    function automatic int isqrt_latency(input int steps_per_cycle);
        return ISQRT_Y_W / steps_per_cycle;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: pull in the next two radicand bits,
// try to subtract (root<<2)|1, and shift the resulting bit into the root.
module isqrt_step
    import isqrt_pkg::*;
(
    input  logic [ISQRT_R_W-1:0] rem,
    input  logic [ISQRT_Y_W-1:0] root,
    input  logic [ISQRT_X_W-1:0] rad,
    output logic [ISQRT_R_W-1:0] rem_nxt,
    output logic [ISQRT_Y_W-1:0] root_nxt,
    output logic [ISQRT_X_W-1:0] rad_nxt
);

    logic [ISQRT_R_W-1:0] shifted;
    logic [ISQRT_R_W-1:0] trial;
    logic                 ge;
    logic                 unused_hi;

    // The remainder never exceeds 2*root and the root has at most 15 bits
    // before the last step, so rem[17:16] are always zero on entry and
    // dropping them in the shift loses nothing.
    assign shifted   = {rem[ISQRT_R_W-3:0], rad[ISQRT_X_W-1 -: 2]};
    assign trial     = {root, 2'b01};
    assign ge        = (shifted >= trial);
    assign rem_nxt   = ge ? (shifted - trial) : shifted;
    assign root_nxt  = {root[ISQRT_Y_W-2:0], ge};
    assign rad_nxt   = {rad[ISQRT_X_W-3:0], 2'b00};
    assign unused_hi = ^rem[ISQRT_R_W-1 -: 2];

endmodule

// File: rtl/isqrt_iter.sv
// Iterative 32-bit integer square root. Resolves STEPS_PER_CYCLE root bits per
// clock through a chain of combinational digit steps; fixed latency of
// 16/STEPS_PER_CYCLE cycles. Requests arriving while busy are dropped and flagged.
module isqrt_iter
    import isqrt_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_vld,
    input  logic [ISQRT_X_W-1:0] x,
    output logic                 y_vld,
    output logic [ISQRT_Y_W-1:0] y,
    output logic                 busy,
    output logic                 drop
);

    localparam int CYCLES = isqrt_latency(STEPS_PER_CYCLE);
    localparam int CNT_W  = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ISQRT_R_W-1:0] rem;
    logic [ISQRT_Y_W-1:0] root;
    logic [ISQRT_X_W-1:0] rad;

    // Step chain: index 0 is the registered state, index STEPS_PER_CYCLE the
    // value to register at the end of this cycle.
    logic [STEPS_PER_CYCLE:0][ISQRT_R_W-1:0] rem_c;
    logic [STEPS_PER_CYCLE:0][ISQRT_Y_W-1:0] root_c;
    logic [STEPS_PER_CYCLE:0][ISQRT_X_W-1:0] rad_c;

    assign rem_c[0]  = rem;
    assign root_c[0] = root;
    assign rad_c[0]  = rad;

    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
        isqrt_step u_step (
            .rem      (rem_c[gi]),
            .root     (root_c[gi]),
            .rad      (rad_c[gi]),
            .rem_nxt  (rem_c[gi+1]),
            .root_nxt (root_c[gi+1]),
            .rad_nxt  (rad_c[gi+1])
        );
    end

    assign busy = (state == CALC);

    // Control FSM plus datapath registers; y_vld and drop are single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            root  <= '0;
            rad   <= '0;
            y     <= '0;
            y_vld <= 1'b0;
            drop  <= 1'b0;
        end else begin
            y_vld <= 1'b0;
            drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_vld) begin
                        rad   <= x;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem  <= rem_c[STEPS_PER_CYCLE];
                    root <= root_c[STEPS_PER_CYCLE];
                    rad  <= rad_c[STEPS_PER_CYCLE];
                    if (x_vld) drop <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        y     <= root_c[STEPS_PER_CYCLE];
                        y_vld <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
